// File: rtl/writeback_unit.sv
// ---------------------------------------------------------------------------
// writeback_unit
//   Arbitrates ALU and LSU results onto a single registered register-file
//   write port and tracks registers with outstanding long-latency writes.
//
//   LSU wins by default. After two consecutive ALU stalls, the ALU is forced
//   through for one cycle so it cannot starve.
//
//   Ports
//     clk_i, rst_n_i                      clock, async active-low reset
//     alu_valid_i/alu_rd_i/alu_data_i     ALU result offer
//     alu_ready_o                         ALU result accepted this cycle
//     lsu_valid_i/lsu_rd_i/lsu_data_i     LSU result offer
//     lsu_ready_o                         LSU result accepted this cycle
//     pend_set_i/pend_rd_i                long-latency op issued to pend_rd_i
//     chk_rs1_i/chk_rs2_i/chk_rd_i        decode registers to hazard-check
//     hazard_o                            a checked register is pending
//     rf_wen_o/rf_waddr_o/rf_wdata_o      registered register-file write port
//
//   Optional feature, enabled by defining WB_BYPASS_EN:
//     byp_valid_o/byp_addr_o/byp_data_o   mirror of the write port. Also, the
//     register being written this cycle is not reported as a hazard.
// ---------------------------------------------------------------------------
module writeback_unit #(
  parameter int unsigned AWIDTH = 5,
  parameter int unsigned DWIDTH = 32
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              alu_valid_i,
  input  logic [AWIDTH-1:0] alu_rd_i,
  input  logic [DWIDTH-1:0] alu_data_i,
  output logic              alu_ready_o,
  input  logic              lsu_valid_i,
  input  logic [AWIDTH-1:0] lsu_rd_i,
  input  logic [DWIDTH-1:0] lsu_data_i,
  output logic              lsu_ready_o,
  input  logic              pend_set_i,
  input  logic [AWIDTH-1:0] pend_rd_i,
  input  logic [AWIDTH-1:0] chk_rs1_i,
  input  logic [AWIDTH-1:0] chk_rs2_i,
  input  logic [AWIDTH-1:0] chk_rd_i,
  output logic              hazard_o,
  output logic              rf_wen_o,
  output logic [AWIDTH-1:0] rf_waddr_o,
  output logic [DWIDTH-1:0] rf_wdata_o
`ifdef WB_BYPASS_EN
  ,
  output logic              byp_valid_o,
  output logic [AWIDTH-1:0] byp_addr_o,
  output logic [DWIDTH-1:0] byp_data_o
`endif
);

  localparam int unsigned NREG       = 2 ** AWIDTH;
  localparam logic [1:0]  STARVE_MAX = 2'd2;

  logic [1:0]        starve_q, starve_d;
  logic              alu_force;
  logic              alu_xfer, lsu_xfer;
  logic [NREG-1:0]   pend_q, pend_d;
  logic [NREG-1:0]   hz_mask;
  logic              wr_en_d;
  logic [AWIDTH-1:0] wr_addr_d;
  logic [DWIDTH-1:0] wr_data_d;

  // Arbitration: readies depend only on valids and the starvation counter.
  assign alu_force   = (starve_q == STARVE_MAX);
  assign lsu_ready_o = lsu_valid_i & ~alu_force;
  assign alu_ready_o = ~lsu_valid_i | alu_force;
  assign alu_xfer    = alu_valid_i & alu_ready_o;
  assign lsu_xfer    = lsu_valid_i & lsu_ready_o;

  // Count consecutive ALU stalls; saturates naturally since force grants ALU.
  always_comb begin
    starve_d = starve_q;
    if (!alu_valid_i || alu_xfer) begin
      starve_d = 2'd0;
    end else begin
      starve_d = starve_q + 2'd1;
    end
  end

  // Select the accepted result; the two transfers are mutually exclusive.
  always_comb begin
    wr_en_d   = 1'b0;
    wr_addr_d = alu_rd_i;
    wr_data_d = alu_data_i;
    if (lsu_xfer) begin
      wr_en_d   = (lsu_rd_i != '0);
      wr_addr_d = lsu_rd_i;
      wr_data_d = lsu_data_i;
    end else if (alu_xfer) begin
      wr_en_d   = (alu_rd_i != '0);
    end
  end

  // Pending scoreboard: LSU completion clears, issue sets, set wins.
  always_comb begin
    pend_d = pend_q;
    if (lsu_xfer) begin
      pend_d[lsu_rd_i] = 1'b0;
    end
    if (pend_set_i) begin
      pend_d[pend_rd_i] = 1'b1;
    end
    pend_d[0] = 1'b0;
  end

  // Hazard lookup against current state.
  always_comb begin
    hz_mask = pend_q;
`ifdef WB_BYPASS_EN
    if (rf_wen_o) begin
      hz_mask[rf_waddr_o] = 1'b0;
    end
`endif
    hazard_o = hz_mask[chk_rs1_i] | hz_mask[chk_rs2_i] | hz_mask[chk_rd_i];
  end

  // State and write-port registers; address/data only move on a real write.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q   <= 2'd0;
      pend_q     <= '0;
      rf_wen_o   <= 1'b0;
      rf_waddr_o <= '0;
      rf_wdata_o <= '0;
    end else begin
      starve_q <= starve_d;
      pend_q   <= pend_d;
      rf_wen_o <= wr_en_d;
      if (wr_en_d) begin
        rf_waddr_o <= wr_addr_d;
        rf_wdata_o <= wr_data_d;
      end
    end
  end

`ifdef WB_BYPASS_EN
  assign byp_valid_o = rf_wen_o;
  assign byp_addr_o  = rf_waddr_o;
  assign byp_data_o  = rf_wdata_o;
`endif

endmodule

// File: tb/tb_writeback_unit.sv
// ---------------------------------------------------------------------------
// tb_writeback_unit
//   Scoreboard bench for writeback_unit (default build). A driver applies one
//   stimulus per cycle, checks the combinational readies and hazard against a
//   reference model, and queues the register-file write it expects. A monitor
//   pops and compares whenever the write port asserts rf_wen_o.
// ---------------------------------------------------------------------------
module tb_writeback_unit;

  localparam int unsigned AW = 5;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alu_valid, lsu_valid, pend_set;
  logic [AW-1:0] alu_rd, lsu_rd, pend_rd, chk_rs1, chk_rs2, chk_rd;
  logic [DW-1:0] alu_data, lsu_data;
  logic          alu_ready, lsu_ready, hazard, rf_wen;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;

  writeback_unit #(.AWIDTH(AW), .DWIDTH(DW)) dut (
    .clk_i       (clk),
    .rst_n_i     (rst_n),
    .alu_valid_i (alu_valid),
    .alu_rd_i    (alu_rd),
    .alu_data_i  (alu_data),
    .alu_ready_o (alu_ready),
    .lsu_valid_i (lsu_valid),
    .lsu_rd_i    (lsu_rd),
    .lsu_data_i  (lsu_data),
    .lsu_ready_o (lsu_ready),
    .pend_set_i  (pend_set),
    .pend_rd_i   (pend_rd),
    .chk_rs1_i   (chk_rs1),
    .chk_rs2_i   (chk_rs2),
    .chk_rd_i    (chk_rd),
    .hazard_o    (hazard),
    .rf_wen_o    (rf_wen),
    .rf_waddr_o  (rf_waddr),
    .rf_wdata_o  (rf_wdata)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  typedef struct packed {
    logic          av;
    logic [AW-1:0] ard;
    logic [DW-1:0] ad;
    logic          lv;
    logic [AW-1:0] lrd;
    logic [DW-1:0] ld;
    logic          ps;
    logic [AW-1:0] prd;
    logic [AW-1:0] c1;
    logic [AW-1:0] c2;
    logic [AW-1:0] c3;
  } stim_t;

  wr_t           exp_q[$];
  int            checks   = 0;
  int            failures = 0;
  bit            pend_m[32];
  int            alu_losses = 0;
  bit            mon_en = 1'b0;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_data;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) pend_m[i] = 1'b0;
    alu_losses = 0;
    exp_q.delete();
    last_addr = '0;
    last_data = '0;
  endtask

  // One clock of stimulus: drive, check against the model, advance the model.
  task automatic cycle(input stim_t s);
    bit forced, exp_lr, exp_ar, exp_hz;
    wr_t w;
    @(negedge clk);
    alu_valid = s.av;  alu_rd = s.ard;  alu_data = s.ad;
    lsu_valid = s.lv;  lsu_rd = s.lrd;  lsu_data = s.ld;
    pend_set  = s.ps;  pend_rd = s.prd;
    chk_rs1   = s.c1;  chk_rs2 = s.c2;  chk_rd = s.c3;
    #1;
    // ALU gets through after it has been refused twice in a row.
    forced = (alu_losses >= 2);
    exp_lr = s.lv && !forced;
    exp_ar = !s.lv || forced;
    exp_hz = pend_m[s.c1] || pend_m[s.c2] || pend_m[s.c3];
    check("lsu_ready", 64'(lsu_ready), 64'(exp_lr));
    check("alu_ready", 64'(alu_ready), 64'(exp_ar));
    check("hazard", 64'(hazard), 64'(exp_hz));
    if (s.lv && exp_lr) begin
      if (s.lrd != 0) begin
        w.addr = s.lrd; w.data = s.ld; exp_q.push_back(w);
      end
      pend_m[s.lrd] = 1'b0;
    end else if (s.av && exp_ar) begin
      if (s.ard != 0) begin
        w.addr = s.ard; w.data = s.ad; exp_q.push_back(w);
      end
    end
    if (s.av && !exp_ar) alu_losses++;
    else alu_losses = 0;
    if (s.ps && s.prd != 0) pend_m[s.prd] = 1'b1;
  endtask

  // Monitor: each write must appear exactly one edge after its transfer.
  always @(posedge clk) begin
    wr_t e;
    #1;
    if (mon_en) begin
      if (rf_wen === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("wb_unexpected_write", 64'(rf_waddr), 64'(0));
          check("wb_unexpected_wen", 64'(rf_wen), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("wb_addr", 64'(rf_waddr), 64'(e.addr));
          check("wb_data", 64'(rf_wdata), 64'(e.data));
          last_addr = e.addr;
          last_data = e.data;
        end
      end else begin
        check("wb_hold_addr", 64'(rf_waddr), 64'(last_addr));
        check("wb_hold_data", 64'(rf_wdata), 64'(last_data));
      end
      check("wb_latency_backlog", 64'(exp_q.size()), 64'(0));
      exp_q.delete();
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    logic [3:0] exp30;

    rst_n = 1'b0;
    alu_valid = 0; lsu_valid = 0; pend_set = 0;
    alu_rd = '0; lsu_rd = '0; pend_rd = '0; chk_rs1 = '0; chk_rs2 = '0; chk_rd = '0;
    alu_data = '0; lsu_data = '0;
    model_reset();
    #1;
    check("reset_wen", 64'(rf_wen), 64'(0));
    check("reset_waddr", 64'(rf_waddr), 64'(0));
    check("reset_wdata", 64'(rf_wdata), 64'(0));
    check("reset_hazard", 64'(hazard), 64'(0));
    mon_en = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // ALU-only write to r5.
    s = '0; s.av = 1; s.ard = 5; s.ad = 32'hDEAD_BEEF;
    cycle(s);
    check("alu_only_ready", 64'(alu_ready), 64'(1));
    @(posedge clk); #2;
    check("alu_only_wen", 64'(rf_wen), 64'(1));
    check("alu_only_waddr", 64'(rf_waddr), 64'(5));
    check("alu_only_wdata", 64'(rf_wdata), 64'(32'hDEAD_BEEF));

    // Contention for four cycles: LSU, LSU, ALU (forced), LSU.
    exp30 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      s = '0; s.av = 1; s.ard = AW'(20 + i); s.ad = $urandom;
      s.lv = 1; s.lrd = AW'(10 + i); s.ld = $urandom;
      cycle(s);
      check("contend_lsu_ready", 64'(lsu_ready), 64'(exp30[i]));
      check("contend_alu_ready", 64'(alu_ready), 64'(!exp30[i]));
    end

    // Pending r7 until its LSU result lands.
    s = '0; s.ps = 1; s.prd = 7;
    cycle(s);
    for (int i = 0; i < 2; i++) begin
      s = '0; s.c2 = 7;
      cycle(s);
      check("pend7_hazard", 64'(hazard), 64'(1));
    end
    s = '0; s.c2 = 7; s.lv = 1; s.lrd = 7; s.ld = $urandom;
    cycle(s);
    check("pend7_hazard_at_xfer", 64'(hazard), 64'(1));
    s = '0; s.c2 = 7;
    cycle(s);
    check("pend7_hazard_cleared", 64'(hazard), 64'(0));

    // Set and clear of r9 in the same cycle: set wins.
    s = '0; s.ps = 1; s.prd = 9; s.lv = 1; s.lrd = 9; s.ld = $urandom;
    cycle(s);
    s = '0; s.c1 = 9;
    cycle(s);
    check("set_wins_hazard", 64'(hazard), 64'(1));

    // LSU write to r0: accepted, no write, scoreboard untouched.
    s = '0; s.lv = 1; s.lrd = 0; s.ld = 32'h1234; s.c1 = 9;
    cycle(s);
    check("rd0_lsu_ready", 64'(lsu_ready), 64'(1));
    @(posedge clk); #2;
    check("rd0_wen", 64'(rf_wen), 64'(0));
    s = '0; s.c1 = 9;
    cycle(s);
    check("rd0_pending_kept", 64'(hazard), 64'(1));

    // Asynchronous reset with r3 pending and a write on the port.
    s = '0; s.ps = 1; s.prd = 3;
    cycle(s);
    s = '0; s.av = 1; s.ard = 4; s.ad = $urandom; s.c1 = 3;
    cycle(s);
    @(negedge clk);
    alu_valid = 1; lsu_valid = 1; chk_rs1 = 3; pend_set = 0;
    #1;
    check("pre_reset_wen", 64'(rf_wen), 64'(1));
    check("pre_reset_hazard", 64'(hazard), 64'(1));
    rst_n = 1'b0;
    model_reset();
    #1;
    check("mid_reset_wen", 64'(rf_wen), 64'(0));
    check("mid_reset_waddr", 64'(rf_waddr), 64'(0));
    check("mid_reset_hazard", 64'(hazard), 64'(0));
    check("mid_reset_lsu_ready", 64'(lsu_ready), 64'(1));
    check("mid_reset_alu_ready", 64'(alu_ready), 64'(0));
    repeat (2) @(negedge clk);
    alu_valid = 0; lsu_valid = 0;
    rst_n = 1'b1;
    s = '0; s.c1 = 3;
    cycle(s);
    check("post_reset_hazard", 64'(hazard), 64'(0));

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      s.av  = ($urandom % 2) == 0;
      s.ard = AW'($urandom);
      s.ad  = $urandom;
      s.lv  = ($urandom % 4) != 0;
      s.lrd = AW'($urandom);
      s.ld  = $urandom;
      s.ps  = ($urandom % 3) == 0;
      s.prd = AW'($urandom);
      s.c1  = AW'($urandom);
      s.c2  = AW'($urandom);
      s.c3  = AW'($urandom);
      cycle(s);
    end
    s = '0;
    cycle(s);
    @(posedge clk); #3;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
